// File: rtl/dma_mc.sv
// Multi-channel DMA controller: per-channel SRC/DST/LEN/CTRL registers feeding one
// shared ARB/RD/WR engine that moves one word per arbitration round.
module dma_mc #(
    parameter int NCH = 2,
    parameter int AW  = 8,
    parameter int DW  = 32,
    parameter int LW  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                          cfg_reg,
    input  logic [DW-1:0]                       cfg_wdata,
    output logic                                bus_req,
    input  logic                                bus_gnt,
    output logic [AW-1:0]                       mem_addr,
    output logic                                mem_re,
    output logic                                mem_we,
    output logic [DW-1:0]                       mem_wdata,
    input  logic [DW-1:0]                       mem_rdata,
    output logic [NCH-1:0]                      busy,
    output logic [NCH-1:0]                      eop,
    output logic [NCH-1:0]                      err
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ALIGN = $clog2(DW / 8);
    localparam logic [AW-1:0] STEP  = AW'(DW / 8);
    localparam logic [AW-1:0] AMASK = ~((AW'(1) << ALIGN) - AW'(1));

    typedef enum logic [1:0] {ARB = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cur_q, cur_d, ptr_q, ptr_d, sel_s;
    logic            rd_pend_q, rd_pend_d, found_s;
    logic [DW-1:0]   hold_q, hold_d;
    logic [AW-1:0]   src_q [NCH];
    logic [AW-1:0]   src_d [NCH];
    logic [AW-1:0]   dst_q [NCH];
    logic [AW-1:0]   dst_d [NCH];
    logic [LW-1:0]   len_q [NCH];
    logic [LW-1:0]   len_d [NCH];
    // Full-width copy of the last SRC write, used as the fill pattern.
    logic [DW-1:0]   pat_q [NCH];
    logic [DW-1:0]   pat_d [NCH];
    logic [NCH-1:0]  fill_q, fill_d, busy_q, busy_d, eop_q, eop_d, err_q, err_d;

    assign busy    = busy_q;
    assign eop     = eop_q;
    assign err     = err_q;
    assign bus_req = |busy_q;

    // Round-robin pick, config register writes, and engine sequencing.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        ptr_d     = ptr_q;
        rd_pend_d = 1'b0;
        hold_d    = rd_pend_q ? mem_rdata : hold_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        pat_d     = pat_q;
        fill_d    = fill_q;
        busy_d    = busy_q;
        err_d     = err_q;
        eop_d     = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        found_s   = 1'b0;
        sel_s     = '0;

        for (int i = 0; i < NCH; i++) begin
            if (!found_s && busy_q[(int'(ptr_q) + i) % NCH]) begin
                found_s = 1'b1;
                sel_s   = CW'((int'(ptr_q) + i) % NCH);
            end
        end

        // A busy channel ignores writes, which also drops any write racing its commit.
        if (cfg_we && (int'(cfg_ch) < NCH) && !busy_q[cfg_ch]) begin
            case (cfg_reg)
                2'd0: begin
                    src_d[cfg_ch] = cfg_wdata[AW-1:0] & AMASK;
                    pat_d[cfg_ch] = cfg_wdata;
                end
                2'd1: dst_d[cfg_ch] = cfg_wdata[AW-1:0] & AMASK;
                2'd2: len_d[cfg_ch] = cfg_wdata[LW-1:0];
                2'd3: begin
                    if (cfg_wdata[0]) begin
                        if (len_q[cfg_ch] == LW'(0)) begin
                            err_d[cfg_ch] = 1'b1;
                            eop_d[cfg_ch] = 1'b1;
                        end else begin
                            busy_d[cfg_ch] = 1'b1;
                            err_d[cfg_ch]  = 1'b0;
                            fill_d[cfg_ch] = cfg_wdata[1];
                        end
                    end else begin
                        fill_d[cfg_ch] = fill_q[cfg_ch];
                    end
                end
                default: len_d[cfg_ch] = len_q[cfg_ch];
            endcase
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ARB: begin
                if (found_s) begin
                    cur_d   = sel_s;
                    ptr_d   = CW'((int'(sel_s) + 1) % NCH);
                    state_d = fill_q[sel_s] ? WR : RD;
                end else begin
                    state_d = ARB;
                end
            end
            RD: begin
                mem_addr = src_q[cur_q];
                mem_re   = bus_gnt;
                if (bus_gnt) begin
                    rd_pend_d = 1'b1;
                    state_d   = WR;
                end else begin
                    state_d = RD;
                end
            end
            WR: begin
                mem_addr  = dst_q[cur_q];
                mem_we    = bus_gnt;
                // Read data arrives the cycle after the read strobe; afterwards it lives in hold_q.
                mem_wdata = fill_q[cur_q] ? pat_q[cur_q] : (rd_pend_q ? mem_rdata : hold_q);
                if (bus_gnt) begin
                    dst_d[cur_q] = dst_q[cur_q] + STEP;
                    if (!fill_q[cur_q]) begin
                        src_d[cur_q] = src_q[cur_q] + STEP;
                    end else begin
                        src_d[cur_q] = src_q[cur_q];
                    end
                    len_d[cur_q] = len_q[cur_q] - LW'(1);
                    if (len_q[cur_q] == LW'(1)) begin
                        busy_d[cur_q] = 1'b0;
                        eop_d[cur_q]  = 1'b1;
                    end else begin
                        busy_d[cur_q] = busy_q[cur_q];
                    end
                    state_d = ARB;
                end else begin
                    state_d = WR;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State and channel register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            cur_q     <= '0;
            ptr_q     <= '0;
            rd_pend_q <= 1'b0;
            hold_q    <= '0;
            fill_q    <= '0;
            busy_q    <= '0;
            eop_q     <= '0;
            err_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                len_q[i] <= '0;
                pat_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            ptr_q     <= ptr_d;
            rd_pend_q <= rd_pend_d;
            hold_q    <= hold_d;
            fill_q    <= fill_d;
            busy_q    <= busy_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            pat_q     <= pat_d;
        end
    end
endmodule

// File: tb/tb_dma_mc.sv
// Directed self-checking bench for dma_mc with a registered-read word memory model.
`timescale 1ns/1ps
module tb_dma_mc;
    logic        clk = 1'b0;
    logic        rst, cfg_we, bus_req, bus_gnt, mem_re, mem_we, preload;
    logic [0:0]  cfg_ch;
    logic [1:0]  cfg_reg;
    logic [31:0] cfg_wdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [1:0]  busy, eop, err;

    logic [31:0] mem [64];
    logic [7:0]  wlog [256];
    int we_cnt, re_cnt, bad_cnt, eop_cnt0, eop_cnt1;
    int errors, checks;

    dma_mc #(.NCH(2), .AW(8), .DW(32), .LW(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reg(cfg_reg),
        .cfg_wdata(cfg_wdata), .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .eop(eop), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model plus strobe/eop bookkeeping.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
        if (mem_we) begin
            wlog[we_cnt[7:0]] <= mem_addr;
            we_cnt <= we_cnt + 1;
        end
        if (mem_re) re_cnt <= re_cnt + 1;
        if ((mem_re || mem_we) && !bus_gnt) bad_cnt <= bad_cnt + 1;
        if (eop[0]) eop_cnt0 <= eop_cnt0 + 1;
        if (eop[1]) eop_cnt1 <= eop_cnt1 + 1;
    end

    task automatic cfg_wr(input int ch, input int r, input logic [31:0] d);
        cfg_we = 1'b1; cfg_ch = ch[0:0]; cfg_reg = r[1:0]; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; preload = 1'b1; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_reg = 2'd0;
        cfg_wdata = 32'd0; bus_gnt = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, eop, err, bus_req, mem_re, mem_we} !== 9'd0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_during got=%b addr=%0h wd=%0h exp all 0", {busy, eop, err, bus_req, mem_re, mem_we}, mem_addr, mem_wdata);
        end
        rst = 1'b0; preload = 1'b0; bus_gnt = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, eop, err, bus_req, mem_re, mem_we} !== 9'd0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_after got=%b addr=%0h wd=%0h exp all 0", {busy, eop, err, bus_req, mem_re, mem_we}, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_single_copy;
        int n;
        cfg_wr(0, 0, 32'd128); cfg_wr(0, 1, 32'd192); cfg_wr(0, 2, 32'd2); cfg_wr(0, 3, 32'd1);
        n = 1;
        while (eop[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n !== 7) begin errors++; $display("FAIL copy_eop_latency got=%0d exp=7", n); end
        checks++;
        if (busy[0] !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL copy_busy_end got=%b/%b exp=0/0", busy[0], bus_req); end
        @(negedge clk);
        checks++;
        if (eop[0] !== 1'b0) begin errors++; $display("FAIL copy_eop_pulse got=%b exp=0", eop[0]); end
        checks++;
        if (mem[48] !== 32'hC0DE_0020 || mem[49] !== 32'hC0DE_0021) begin
            errors++; $display("FAIL copy_data got=%h,%h exp=c0de0020,c0de0021", mem[48], mem[49]);
        end
    endtask

    task automatic test_concurrent;
        int base, e0, e1, n;
        logic [7:0] exp_a [6];
        exp_a = '{8'd64, 8'd128, 8'd68, 8'd132, 8'd72, 8'd136};
        cfg_wr(0, 0, 32'd0); cfg_wr(0, 1, 32'd64); cfg_wr(0, 2, 32'd3);
        cfg_wr(1, 0, 32'hA5A5_A5A5); cfg_wr(1, 1, 32'd128); cfg_wr(1, 2, 32'd3);
        base = we_cnt; e0 = eop_cnt0; e1 = eop_cnt1;
        cfg_wr(0, 3, 32'd1); cfg_wr(1, 3, 32'd3);
        n = 0;
        while (busy !== 2'b00 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (n >= 100 || we_cnt - base !== 6) begin errors++; $display("FAIL conc_count writes=%0d exp=6 cycles=%0d", we_cnt - base, n); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (wlog[8'(base + k)] !== exp_a[k]) begin errors++; $display("FAIL conc_order[%0d] got=%0d exp=%0d", k, wlog[8'(base + k)], exp_a[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem[32 + k] !== 32'hA5A5_A5A5 || mem[16 + k] !== (32'hC0DE_0000 | 32'(k))) begin
                errors++; $display("FAIL conc_data[%0d] fill=%h copy=%h", k, mem[32 + k], mem[16 + k]);
            end
        end
        checks++;
        if (eop_cnt0 - e0 !== 1 || eop_cnt1 - e1 !== 1) begin errors++; $display("FAIL conc_eops got=%0d,%0d exp=1,1", eop_cnt0 - e0, eop_cnt1 - e1); end
    endtask

    task automatic test_throttle;
        int bw, br, bb, e0, k;
        cfg_wr(0, 0, 32'd16); cfg_wr(0, 1, 32'd160); cfg_wr(0, 2, 32'd4);
        bw = we_cnt; br = re_cnt; bb = bad_cnt; e0 = eop_cnt0;
        cfg_wr(0, 3, 32'd1);
        k = 0;
        while (busy !== 2'b00 && k < 200) begin bus_gnt = k[1]; @(negedge clk); k++; end
        bus_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (k >= 200 || bad_cnt !== bb) begin errors++; $display("FAIL thr_gnt strobes_without_gnt=%0d exp=0 cycles=%0d", bad_cnt - bb, k); end
        checks++;
        if (we_cnt - bw !== 4 || re_cnt - br !== 4 || eop_cnt0 - e0 !== 1) begin
            errors++; $display("FAIL thr_counts we=%0d re=%0d eop=%0d exp=4,4,1", we_cnt - bw, re_cnt - br, eop_cnt0 - e0);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (mem[40 + j] !== (32'hC0DE_0004 + 32'(j))) begin errors++; $display("FAIL thr_data[%0d] got=%h exp=%h", j, mem[40 + j], 32'hC0DE_0004 + 32'(j)); end
        end
    endtask

    task automatic test_len0;
        int bw, br, e1, n;
        cfg_wr(1, 2, 32'd0);
        bw = we_cnt; br = re_cnt; e1 = eop_cnt1;
        cfg_wr(1, 3, 32'd1);
        checks++;
        if (eop[1] !== 1'b1 || err[1] !== 1'b1 || busy[1] !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL len0_flags eop=%b err=%b busy=%b req=%b exp=1,1,0,0", eop[1], err[1], busy[1], bus_req);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (we_cnt !== bw || re_cnt !== br || eop_cnt1 - e1 !== 1 || err[1] !== 1'b1) begin
            errors++; $display("FAIL len0_after strobes=%0d eops=%0d err=%b exp=0,1,1", we_cnt - bw + re_cnt - br, eop_cnt1 - e1, err[1]);
        end
        cfg_wr(1, 0, 32'h1111_1111); cfg_wr(1, 1, 32'd236); cfg_wr(1, 2, 32'd1); cfg_wr(1, 3, 32'd3);
        checks++;
        if (err[1] !== 1'b0 || busy[1] !== 1'b1) begin errors++; $display("FAIL len0_restart err=%b busy=%b exp=0,1", err[1], busy[1]); end
        n = 0;
        while (busy !== 2'b00 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (mem[59] !== 32'h1111_1111) begin errors++; $display("FAIL len0_fill got=%h exp=11111111", mem[59]); end
    endtask

    task automatic test_reset_mid;
        int base, e0, bw, br, n;
        cfg_wr(0, 0, 32'd32); cfg_wr(0, 1, 32'd200); cfg_wr(0, 2, 32'd5);
        base = we_cnt; e0 = eop_cnt0;
        cfg_wr(0, 3, 32'd1);
        n = 0;
        while (we_cnt - base < 2 && n < 50) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, eop, err, bus_req, mem_re, mem_we} !== 9'd0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL rstmid_outs got=%b addr=%0h exp all 0", {busy, eop, err, bus_req, mem_re, mem_we}, mem_addr);
        end
        bw = we_cnt; br = re_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (we_cnt !== bw || re_cnt !== br || eop_cnt0 !== e0 || busy !== 2'b00) begin
            errors++; $display("FAIL rstmid_quiet we=%0d re=%0d eop=%0d busy=%b exp 0,0,0,00", we_cnt - bw, re_cnt - br, eop_cnt0 - e0, busy);
        end
        checks++;
        if (mem[50] !== 32'hC0DE_0008 || mem[51] !== 32'hC0DE_0009 || mem[52] !== 32'hC0DE_0034) begin
            errors++; $display("FAIL rstmid_data got=%h,%h,%h exp=c0de0008,c0de0009,c0de0034", mem[50], mem[51], mem[52]);
        end
        e0 = eop_cnt0;
        cfg_wr(0, 0, 32'd52); cfg_wr(0, 1, 32'd224); cfg_wr(0, 2, 32'd2); cfg_wr(0, 3, 32'd1);
        n = 0;
        while (busy !== 2'b00 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (mem[56] !== 32'hC0DE_000D || mem[57] !== 32'hC0DE_000E || eop_cnt0 - e0 !== 1) begin
            errors++; $display("FAIL rstmid_fresh got=%h,%h eops=%0d exp=c0de000d,c0de000e,1", mem[56], mem[57], eop_cnt0 - e0);
        end
    endtask

    task automatic test_wrap;
        int base, n;
        cfg_wr(0, 0, 32'd100); cfg_wr(0, 1, 32'd252); cfg_wr(0, 2, 32'd2);
        base = we_cnt;
        cfg_wr(0, 3, 32'd1);
        n = 0;
        while (busy !== 2'b00 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (wlog[8'(base)] !== 8'd252 || wlog[8'(base + 1)] !== 8'd0 || we_cnt - base !== 2) begin
            errors++; $display("FAIL wrap_addr got=%0d,%0d n=%0d exp=252,0 n=2", wlog[8'(base)], wlog[8'(base + 1)], we_cnt - base);
        end
        checks++;
        if (mem[63] !== 32'hC0DE_0019 || mem[0] !== 32'hC0DE_001A || err[0] !== 1'b0) begin
            errors++; $display("FAIL wrap_data got=%h,%h err=%b exp=c0de0019,c0de001a,0", mem[63], mem[0], err[0]);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        test_reset;
        test_single_copy;
        test_concurrent;
        test_throttle;
        test_len0;
        test_reset_mid;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
